// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master round-robin arbiter in front of one dp_ram port.
// Grants are combinational. The single read/write response comes back as a one-cycle rvalid to the granted master.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);
  logic       prio_q;
  logic [1:0] rvalid_q;
  logic       unused_addr;
  always_comb begin
    m0_gnt_o    = rst_n & m0_req_i & (~m1_req_i | ~prio_q);
    m1_gnt_o    = rst_n & m1_req_i & (~m0_req_i | prio_q);
    ram_en_o    = m0_gnt_o | m1_gnt_o;
    // With no grant the address and write data fall back to m0, so the mux stays static.
    ram_addr_o  = m1_gnt_o ? m1_addr_i[ADDR_WIDTH+1:2] : m0_addr_i[ADDR_WIDTH+1:2];
    ram_we_o    = m1_gnt_o ? m1_we_i : m0_gnt_o & m0_we_i;
    ram_be_o    = m1_gnt_o ? m1_be_i : m0_gnt_o ? m0_be_i : 4'h0;
    ram_wdata_o = m1_gnt_o ? m1_wdata_i : m0_wdata_i;
    m0_rvalid_o = rvalid_q[0];
    m1_rvalid_o = rvalid_q[1];
    m0_rdata_o  = ram_rdata_i;
    m1_rdata_o  = ram_rdata_i;
    unused_addr = ^{m0_addr_i[31:ADDR_WIDTH+2], m0_addr_i[1:0], m1_addr_i[31:ADDR_WIDTH+2], m1_addr_i[1:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      if (ram_en_o) prio_q <= m0_gnt_o;
      rvalid_q <= {m1_gnt_o, m0_gnt_o};
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random traffic against a behavioural arbiter/memory model.
// A simple registered RAM sits on the DUT's RAM port. A separate reference memory predicts every response.
module tb_ram_port_arbiter;
  localparam int WORDS = 256;
  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_gnt, m0_we, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0] m0_be;
  logic m1_req, m1_gnt, m1_we, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m1_be;
  logic ram_en, ram_we;
  logic [7:0] ram_addr;
  logic [3:0] ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] ram_mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  int checks = 0;
  int failures = 0;
  int last;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always @(posedge clk)
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we && ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_addr = addr; m0_we = we; m0_be = be; m0_wdata = wd;
    end else begin
      m1_req = req; m1_addr = addr; m1_we = we; m1_be = be; m1_wdata = wd;
    end
  endtask

  // One bus cycle: inputs are already driven just after a falling edge.
  task automatic cycle();
    int w, idx;
    logic we;
    logic [3:0] be;
    logic [31:0] addr, wd, prev;
    #1;
    if (m0_req && m1_req) w = 1 - last;
    else if (m0_req) w = 0;
    else if (m1_req) w = 1;
    else w = -1;
    addr = (w == 1) ? m1_addr : m0_addr;
    we   = (w == 1) ? m1_we : m0_we;
    be   = (w == 1) ? m1_be : m0_be;
    wd   = (w == 1) ? m1_wdata : m0_wdata;
    idx  = int'((addr / 4) % WORDS);
    chk("gnt0", 32'(m0_gnt), 32'(w == 0));
    chk("gnt1", 32'(m1_gnt), 32'(w == 1));
    chk("ram_en", 32'(ram_en), 32'(w >= 0));
    chk("ram_we", 32'(ram_we), 32'(w >= 0 && we));
    chk("ram_be", 32'(ram_be), (w >= 0) ? 32'(be) : 32'd0);
    chk("ram_addr", 32'(ram_addr), idx);
    chk("ram_wdata", ram_wdata, wd);
    @(posedge clk);
    prev = ref_mem[idx];
    if (w >= 0) begin
      last = w;
      if (we)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    #1;
    chk("rvalid0", 32'(m0_rvalid), 32'(w == 0));
    chk("rvalid1", 32'(m1_rvalid), 32'(w == 1));
    if (w >= 0 && !we) begin
      chk("rdata0", m0_rdata, prev);
      chk("rdata1", m1_rdata, prev);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    ram_mem[2] = 32'h11223344; ref_mem[2] = 32'h11223344;
    ram_rdata = 32'h0;
    last = 1;
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    #1;
    chk("rst_gnt0", 32'(m0_gnt), 32'd0);
    chk("rst_gnt1", 32'(m1_gnt), 32'd0);
    chk("rst_en", 32'(ram_en), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_be", 32'(ram_be), 32'd0);
    chk("rst_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    // single read of mem[5]
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(0, 1'b1, 32'h14, 1'b0, 4'hF, 32'h0);
    cycle();
    // sustained contention
    drive(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
    repeat (4) cycle();
    // byte write by m1 then read back
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h8, 1'b1, 4'b0100, 32'h00AB0000);
    cycle();
    drive(1, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0);
    cycle();
    chk("bytewrite_ref", ref_mem[2], 32'h11AB3344);
    // wrap: byte address 0x403 maps to word 0
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(0, 1'b1, 32'h403, 1'b0, 4'hF, 32'h0);
    cycle();
    // idle cycle
    drive(0, 1'b0, 32'h30, 1'b0, 4'hF, 32'h0);
    cycle();
    // reset while an m1 response is pending
    drive(1, 1'b1, 32'hC, 1'b0, 4'hF, 32'h0);
    #1;
    chk("mf_gnt1", 32'(m1_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("mf_rv1", 32'(m1_rvalid), 32'd1);
    drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mf_rv1_clr", 32'(m1_rvalid), 32'd0);
    chk("mf_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("mf_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last = 1;
    cycle();
    // random traffic over a small address window to force collisions
    for (int n = 0; n < 300; n++) begin
      for (int m = 0; m < 2; m++)
        drive(m, 1'($urandom_range(0, 3) != 0), {$urandom_range(0, 255), 6'($urandom_range(0, 63))},
              1'($urandom), 4'($urandom), $urandom);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
